// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding, default clock rate and ms-to-cycles helper for key_debounce
package key_pkg;

   localparam int KEY_CLK_HZ_DEFAULT = 50_000_000;

   typedef enum logic [1:0] {
      REL    = 2'd0,
      WAIT_P = 2'd1,
      PRS    = 2'd2,
      WAIT_R = 2'd3
   } key_state_t;

   // Whole-ms clock count, clamped so a zero-length window still takes one cycle.
   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      int c;
      c = clk_hz / 1000 * ms;
      if (c < 1) c = 1;
      return c;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key: 2-flop synchroniser, debounce FSM, event pulses
// Hold counter and key_long pulse exist only when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DB_CYCLES   = 4,
   parameter int LONG_CYCLES = 10
)(
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic key_db,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int               CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             r_s1, r_s;
   key_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_db, w_db_nxt;
   logic             r_press, w_press_nxt;
   logic             r_release, w_release_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1      <= 1'b1;
         r_s       <= 1'b1;
         r_state   <= REL;
         r_cnt     <= '0;
         r_db      <= 1'b1;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_s1      <= key_raw;
         r_s       <= r_s1;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_db      <= w_db_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   // Any return of s to the old level inside a wait aborts it; cnt saturates at CNT_MAX.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_db_nxt      = r_db;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         REL: begin
            if (!r_s) begin
               w_state_nxt = WAIT_P;
               w_cnt_nxt   = '0;
            end
         end
         WAIT_P: begin
            if (r_s) begin
               w_state_nxt = REL;
            end else if (r_cnt == CNT_MAX) begin
               w_state_nxt = PRS;
               w_db_nxt    = 1'b0;
               w_press_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         PRS: begin
            if (r_s) begin
               w_state_nxt = WAIT_R;
               w_cnt_nxt   = '0;
            end
         end
         WAIT_R: begin
            if (!r_s) begin
               w_state_nxt = PRS;
            end else if (r_cnt == CNT_MAX) begin
               w_state_nxt   = REL;
               w_db_nxt      = 1'b1;
               w_release_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = REL;
      endcase
   end

   assign key_db      = r_db;
   assign key_press   = r_press;
   assign key_release = r_release;

`ifdef KEY_LONG_PRESS_EN
   localparam int                HOLD_W    = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   logic [HOLD_W-1:0] r_hold, w_hold_nxt;
   logic              r_long, w_long_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hold <= '0;
         r_long <= 1'b0;
      end else begin
         r_hold <= w_hold_nxt;
         r_long <= w_long_nxt;
      end
   end

   // Cleared only on an accepted press, so a release bounce back into PRS cannot re-arm it.
   always_comb begin
      w_hold_nxt = r_hold;
      w_long_nxt = 1'b0;
      if (r_state == WAIT_P && w_state_nxt == PRS) begin
         w_hold_nxt = '0;
      end else if ((r_state == PRS || r_state == WAIT_R) && r_hold < HOLD_MAX) begin
         w_hold_nxt = r_hold + 1'b1;
         w_long_nxt = (r_hold == HOLD_LAST);
      end
   end

   assign key_long = r_long;
`else
   assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - N_KEYS independent debounced push buttons with press/release/long pulses
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_debounce
   import key_pkg::*;
#(
   parameter int CLK_HZ      = KEY_CLK_HZ_DEFAULT,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int N_KEYS      = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_db,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long
);

   localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      key_debounce_ch #(
         .DB_CYCLES   (DB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_raw     (key_raw[g]),
         .key_db      (key_db[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g]),
         .key_long    (key_long[g])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce (CLK_HZ=1000, DB=4, LONG=10 cycles)
module tb_key_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] key_raw;
   logic [1:0] key_db, key_press, key_release, key_long;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      name;
      int         cyc;
      logic [1:0] press;
      logic [1:0] rel;
      logic [1:0] lng;
      logic [1:0] db;
   } ev_t;

   ev_t exp_q[$];

   key_debounce #(
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4),
      .LONG_MS     (10),
      .N_KEYS      (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_raw),
      .key_db      (key_db),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_v(input string nm, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_i(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Expected event, registered at edge number cyc+dly as seen from the current negedge.
   task automatic expect_ev(input string nm, input int dly, input logic [1:0] p,
                            input logic [1:0] r, input logic [1:0] l, input logic [1:0] d);
      ev_t e;
      e.name  = nm;
      e.cyc   = cyc + dly;
      e.press = p;
      e.rel   = r;
      e.lng   = l;
      e.db    = d;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if ((key_press | key_release | key_long) !== 2'b00) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: cycle %0d press %b release %b long %b, none expected",
                     cyc, key_press, key_release, key_long);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check_i({e.name, "_cycle"}, cyc, e.cyc);
            check_v({e.name, "_press"}, key_press, e.press);
            check_v({e.name, "_release"}, key_release, e.rel);
            check_v({e.name, "_long"}, key_long, e.lng);
            check_v({e.name, "_db"}, key_db, e.db);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      key_raw = 2'b00;
      tick(3);
      check_v("reset_db", key_db, 2'b11);
      check_v("reset_press", key_press, 2'b00);
      check_v("reset_release", key_release, 2'b00);
      check_v("reset_long", key_long, 2'b00);

      // Both keys held through reset: fresh press after full latency.
      rst_n = 1'b1;
      expect_ev("rst_press", 7, 2'b11, 2'b00, 2'b00, 2'b00);
      tick(10);
      key_raw = 2'b11;
      expect_ev("rst_release", 7, 2'b00, 2'b11, 2'b00, 2'b11);
      tick(10);

      key_raw = 2'b10;
      expect_ev("clean_press", 7, 2'b01, 2'b00, 2'b00, 2'b10);
      tick(10);
      key_raw = 2'b11;
      expect_ev("clean_release", 7, 2'b00, 2'b01, 2'b00, 2'b11);
      tick(10);

      for (int k = 0; k < 10; k++) begin
         key_raw = {1'b1, ((k % 2) == 1)};
         tick(2);
      end
      key_raw = 2'b10;
      expect_ev("bounce_press", 7, 2'b01, 2'b00, 2'b00, 2'b10);
      tick(10);
      key_raw = 2'b11;
      expect_ev("bounce_release", 7, 2'b00, 2'b01, 2'b00, 2'b11);
      tick(10);

      key_raw = 2'b00;
      expect_ev("simul_press", 7, 2'b11, 2'b00, 2'b00, 2'b00);
      tick(10);
      key_raw = 2'b11;
      expect_ev("simul_release", 7, 2'b00, 2'b11, 2'b00, 2'b11);
      tick(10);

      key_raw = 2'b10;
      expect_ev("glitch_press", 7, 2'b01, 2'b00, 2'b00, 2'b10);
      tick(2);
      key_raw = 2'b00;
      tick(1);
      key_raw = 2'b10;
      tick(8);
      key_raw = 2'b11;
      expect_ev("glitch_release", 7, 2'b00, 2'b01, 2'b00, 2'b11);
      tick(10);

      // Reset lands while key 0 is in WAIT_P with cnt==2.
      key_raw = 2'b10;
      tick(5);
      rst_n = 1'b0;
      tick(2);
      check_v("midrst_db", key_db, 2'b11);
      check_v("midrst_press", key_press, 2'b00);
      rst_n = 1'b1;
      expect_ev("midrst_press", 7, 2'b01, 2'b00, 2'b00, 2'b10);
      tick(10);
      key_raw = 2'b11;
      expect_ev("midrst_release", 7, 2'b00, 2'b01, 2'b00, 2'b11);
      tick(10);

      key_raw = 2'b10;
      expect_ev("long_press", 7, 2'b01, 2'b00, 2'b00, 2'b10);
`ifdef KEY_LONG_PRESS_EN
      expect_ev("long_pulse", 17, 2'b00, 2'b00, 2'b01, 2'b10);
`endif
      tick(22);
      key_raw = 2'b11;
      expect_ev("long_release", 7, 2'b00, 2'b01, 2'b00, 2'b11);
      tick(20);

      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_%s: no output seen, expected at cycle %0d", e.name, e.cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
